kpke_ct_encoder: RTL



---
 rtl/kpke_ct_encoder_pkg.sv | 34 +++
 rtl/kpke_ct_encoder_if.sv | 33 +++
 rtl/kpke_ct_encoder_compress.sv | 21 ++
 rtl/kpke_ct_encoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/kpke_ct_encoder_pkg.sv
// Shared constants, types and FSM encoding for the K-PKE ciphertext packer.
// Optional build macro consumed by the encoder: KPKE_CT_ENC_RANGE_CHECK_EN.
package kpke_ct_encoder_pkg;

    localparam int K  = 3;
    localparam int N  = 256;
    localparam int Q  = 3329;
    localparam int DU = 10;
    localparam int DV = 4;

    localparam int C_BYTES    = N / 8 * (K * DU + DV);
    localparam int U_COEFFS   = K * N;
    localparam int ALL_COEFFS = K * N + N;

    localparam int ACC_W  = 18;
    localparam int BC_W   = 5;
    localparam int CNT_W  = 10;
    localparam int BCNT_W = 11;

    // floor(n / Q) == (n * RECIP_M) >> RECIP_SHIFT holds for every n below 2^23
    localparam int          RECIP_SHIFT = 35;
    localparam logic [23:0] RECIP_M     =
        24'(((64'd1 << RECIP_SHIFT) + 64'(Q) - 64'd1) / 64'(Q));

    typedef logic [11:0] coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_U    = 2'd1,
        ST_V    = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/kpke_ct_encoder_if.sv
// Coefficient input stream and packed-byte output stream of the ciphertext packer.
interface kpke_ct_encoder_if;
    import kpke_ct_encoder_pkg::*;

    coeff_t      coeff;
    logic        coeff_valid;
    logic        coeff_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;

    modport master (
        output coeff,
        output coeff_valid,
        input  coeff_ready,
        input  byte_out,
        input  byte_valid,
        output byte_ready,
        input  byte_last
    );

    modport slave (
        input  coeff,
        input  coeff_valid,
        output coeff_ready,
        output byte_out,
        output byte_valid,
        input  byte_ready,
        output byte_last
    );

endinterface

// File: rtl/kpke_ct_encoder_compress.sv
// Combinational Compress_d: round(x * 2^d / Q) mod 2^d via reciprocal multiply, d chosen at run time.
module kpke_ct_encoder_compress
    import kpke_ct_encoder_pkg::*;
(
    input  coeff_t      x_i,
    input  logic [3:0]  d_i,
    output logic [9:0]  c_o
);

    logic [22:0] num;
    logic [46:0] prod;
    logic [9:0]  mask;

    always_comb begin
        num  = (23'(x_i) << d_i) + 23'd1664;
        prod = 47'(num) * 47'(RECIP_M);
        mask = (10'd1 << d_i) - 10'd1;
        c_o  = 10'(prod >> RECIP_SHIFT) & mask;
    end

endmodule

// File: rtl/kpke_ct_encoder.sv
// K-PKE ciphertext packer: compresses K*N u-coefficients then N v-coefficients and packs them LSB-first.
// Optional build macro: KPKE_CT_ENC_RANGE_CHECK_EN adds the sticky range_err_o output.
module kpke_ct_encoder
    import kpke_ct_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    kpke_ct_encoder_if.slave  bus,
    output logic              busy_o,
    output logic              done_o
`ifdef KPKE_CT_ENC_RANGE_CHECK_EN
    ,
    output logic              range_err_o
`endif
);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [BC_W-1:0]     bc_q, bc_d;
    logic [CNT_W-1:0]    coeff_cnt_q, coeff_cnt_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic                coeffs_all_q, coeffs_all_d;

    logic                active;
    logic                more_coeffs;
    logic                coeff_ready;
    logic                byte_valid;
    logic                byte_last;
    logic                push;
    logic                pop;
    logic [3:0]          d_cur;
    coeff_t              x_sel;
    logic [9:0]          comp_c;

`ifdef KPKE_CT_ENC_RANGE_CHECK_EN
    logic                range_err_q, range_err_d;
    logic                coeff_over;

    assign coeff_over  = bus.coeff >= coeff_t'(Q);
    assign x_sel       = coeff_over ? bus.coeff - coeff_t'(Q) : bus.coeff;
    assign range_err_o = range_err_q;
`else
    assign x_sel       = bus.coeff;
`endif

    kpke_ct_encoder_compress u_compress (
        .x_i (x_sel),
        .d_i (d_cur),
        .c_o (comp_c)
    );

    // Handshake qualifiers look only at registered state, so push and pop never coincide.
    always_comb begin
        active      = (state_q == ST_U) || (state_q == ST_V);
        d_cur       = (state_q == ST_V) ? 4'(DV) : 4'(DU);
        more_coeffs = 1'b0;
        if (state_q == ST_U) begin
            more_coeffs = coeff_cnt_q < CNT_W'(U_COEFFS);
        end else if (state_q == ST_V) begin
            more_coeffs = !coeffs_all_q;
        end
        coeff_ready = active && (bc_q < BC_W'(8)) && more_coeffs;
        byte_valid  = bc_q >= BC_W'(8);
        byte_last   = byte_valid && (byte_cnt_q == BCNT_W'(C_BYTES - 1));
        push        = coeff_ready && bus.coeff_valid;
        pop         = byte_valid && bus.byte_ready;
    end

    assign bus.coeff_ready = coeff_ready;
    assign bus.byte_valid  = byte_valid;
    assign bus.byte_last   = byte_last;
    assign bus.byte_out    = acc_q[7:0];
    assign busy_o          = active;
    assign done_o          = (state_q == ST_DONE);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        bc_d         = bc_q;
        coeff_cnt_d  = coeff_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        coeffs_all_d = coeffs_all_q;
`ifdef KPKE_CT_ENC_RANGE_CHECK_EN
        range_err_d  = range_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_U;
                    acc_d        = '0;
                    bc_d         = '0;
                    coeff_cnt_d  = '0;
                    byte_cnt_d   = '0;
                    coeffs_all_d = 1'b0;
`ifdef KPKE_CT_ENC_RANGE_CHECK_EN
                    range_err_d  = 1'b0;
`endif
                end
            end
            ST_U, ST_V: begin
                if (push) begin
                    acc_d = acc_q | (ACC_W'(comp_c) << bc_q);
                    bc_d  = bc_q + BC_W'(d_cur);
                    // The last v coefficient raises a flag instead of wrapping the counter.
                    if (coeff_cnt_q == CNT_W'(ALL_COEFFS - 1)) begin
                        coeffs_all_d = 1'b1;
                    end else begin
                        coeff_cnt_d = coeff_cnt_q + CNT_W'(1);
                    end
`ifdef KPKE_CT_ENC_RANGE_CHECK_EN
                    if (coeff_over) begin
                        range_err_d = 1'b1;
                    end
`endif
                end
                if (pop) begin
                    acc_d      = acc_q >> 8;
                    bc_d       = bc_q - BC_W'(8);
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                end
                if ((state_q == ST_U) && (coeff_cnt_q == CNT_W'(U_COEFFS))
                        && (bc_q < BC_W'(8))) begin
                    state_d = ST_V;
                end
                if ((state_q == ST_V) && pop && byte_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            bc_q         <= '0;
            coeff_cnt_q  <= '0;
            byte_cnt_q   <= '0;
            coeffs_all_q <= 1'b0;
`ifdef KPKE_CT_ENC_RANGE_CHECK_EN
            range_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bc_q         <= bc_d;
            coeff_cnt_q  <= coeff_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            coeffs_all_q <= coeffs_all_d;
`ifdef KPKE_CT_ENC_RANGE_CHECK_EN
            range_err_q  <= range_err_d;
`endif
        end
    end

endmodule
